// File: rtl/ble_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ble_tx_pkg
// Brief   : Shared types and frame constants for the BLE transmit path.
// Revision: 1.0 - initial release
// ============================================================================
package ble_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_AA   = 3'd2,
        ST_PDU  = 3'd3,
        ST_CRC  = 3'd4,
        ST_FIN  = 3'd5
    } ble_tx_state_t;

    localparam int unsigned BLE_PREAMBLE_LEN = 8;
    localparam int unsigned BLE_AA_LEN       = 32;
    localparam int unsigned BLE_CRC_LEN      = 24;
    localparam logic [23:0] BLE_CRC_POLY     = 24'h00065B;

    // Preamble alternates so that its first bit matches the access address LSB.
    function automatic logic [7:0] preamble_pattern(input logic aa_lsb);
        return aa_lsb ? 8'h55 : 8'hAA;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ble_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : ble_tx_sequencer_if
// Brief   : Host control, upstream byte stream and modulator signals.
// Revision: 1.0 - initial release
// ============================================================================
interface ble_tx_sequencer_if;

    logic        start;
    logic [31:0] acc_addr;
    logic [7:0]  pdu_len;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        symVal;
    logic        mod_en;
    logic        busy;
    logic        done;
    logic        underrun;

    modport master (
        output start, acc_addr, pdu_len, byte_data, byte_valid,
        input  byte_ready, symVal, mod_en, busy, done, underrun
    );

    modport slave (
        input  start, acc_addr, pdu_len, byte_data, byte_valid,
        output byte_ready, symVal, mod_en, busy, done, underrun
    );

endinterface
`default_nettype wire

// File: rtl/ble_crc24.sv
`default_nettype none
// ============================================================================
// Module  : ble_crc24
// Brief   : BLE CRC24 Galois LFSR, one bit per shift_en; shared by TX and RX.
// Revision: 1.0 - initial release
// ============================================================================
module ble_crc24
    import ble_tx_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        init,
    input  wire logic [23:0] seed,
    input  wire logic        shift_en,
    input  wire logic        din,
    output logic      [23:0] crc
);

    logic [23:0] crc_q;
    logic [23:0] crc_d;
    logic        w_fb;

    always_comb begin
        w_fb  = din ^ crc_q[23];
        crc_d = crc_q;
        if (init) begin
            crc_d = seed;
        end else if (shift_en) begin
            crc_d = {crc_q[22:0], 1'b0} ^ (w_fb ? BLE_CRC_POLY : 24'h000000);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_q <= 24'h000000;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule
`default_nettype wire

// File: rtl/ble_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : ble_tx_sequencer
// Brief   : Sequences preamble, access address, PDU and CRC24 onto symVal.
// Revision: 1.0 - initial release
// ============================================================================
module ble_tx_sequencer
    import ble_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_SYM = 4,
    parameter logic [23:0] CRC_INIT     = 24'h555555
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ble_tx_sequencer_if.slave  bus
);

    localparam logic [7:0] C_SYM_LAST = 8'(CLKS_PER_SYM - 1);
    localparam logic [4:0] C_PRE_LAST = 5'(BLE_PREAMBLE_LEN - 1);
    localparam logic [4:0] C_AA_LAST  = 5'(BLE_AA_LEN - 1);
    localparam logic [4:0] C_CRC_LAST = 5'(BLE_CRC_LEN - 1);

    ble_tx_state_t state_q;
    logic [7:0]    sym_cnt_q;
    logic [4:0]    bit_cnt_q;
    logic [31:0]   acc_q;
    logic [7:0]    len_q;
    logic [7:0]    shift_q;
    logic [7:0]    hold_q;
    logic          hold_valid_q;
    logic [7:0]    req_q;
    logic [7:0]    load_q;
    logic          sym_q;
    logic          mod_en_q;
    logic          busy_q;
    logic          done_q;
    logic          underrun_q;

    logic          w_sym_wrap;
    logic          w_byte_ready;
    logic          w_byte_acc;
    logic [7:0]    w_byte_src;
    logic          w_byte_avail;
    logic          w_aa_end;
    logic          w_pdu_end;
    logic          w_boundary;
    logic [7:0]    w_pre_pat;
    logic          w_crc_init;
    logic          w_crc_shift;
    logic          w_crc_din;
    logic [23:0]   w_crc;

    always_comb begin
        w_sym_wrap   = (sym_cnt_q == C_SYM_LAST);
        w_byte_ready = busy_q && !hold_valid_q && (req_q < len_q) &&
                       ((state_q == ST_AA) || (state_q == ST_PDU));
        w_byte_acc   = bus.byte_valid && w_byte_ready;
        // A byte arriving on the boundary cycle bypasses the holding register.
        w_byte_src   = hold_valid_q ? hold_q : bus.byte_data;
        w_byte_avail = hold_valid_q || w_byte_acc;
        w_aa_end     = (state_q == ST_AA)  && w_sym_wrap && (bit_cnt_q == C_AA_LAST);
        w_pdu_end    = (state_q == ST_PDU) && w_sym_wrap && (bit_cnt_q == 5'd7);
        w_boundary   = (w_aa_end && (len_q != 8'd0)) || (w_pdu_end && (load_q != len_q));
        w_pre_pat    = preamble_pattern(acc_q[0]);
    end

    // The CRC advances as each PDU bit is launched; during CRC output feeding
    // back crc[23] cancels the feedback and turns the LFSR into a plain shifter.
    always_comb begin
        w_crc_init  = (state_q == ST_IDLE) && bus.start;
        w_crc_shift = 1'b0;
        w_crc_din   = 1'b0;
        if (w_boundary && w_byte_avail) begin
            w_crc_shift = 1'b1;
            w_crc_din   = w_byte_src[0];
        end else if ((state_q == ST_PDU) && w_sym_wrap && (bit_cnt_q != 5'd7)) begin
            w_crc_shift = 1'b1;
            w_crc_din   = shift_q[0];
        end else if ((state_q == ST_CRC) && w_sym_wrap && (bit_cnt_q != C_CRC_LAST)) begin
            w_crc_shift = 1'b1;
            w_crc_din   = w_crc[23];
        end
    end

    ble_crc24 u_crc (
        .clk      (clk),
        .rst      (rst),
        .init     (w_crc_init),
        .seed     (CRC_INIT),
        .shift_en (w_crc_shift),
        .din      (w_crc_din),
        .crc      (w_crc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            sym_cnt_q    <= 8'd0;
            bit_cnt_q    <= 5'd0;
            acc_q        <= 32'd0;
            len_q        <= 8'd0;
            shift_q      <= 8'd0;
            hold_q       <= 8'd0;
            hold_valid_q <= 1'b0;
            req_q        <= 8'd0;
            load_q       <= 8'd0;
            sym_q        <= 1'b0;
            mod_en_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (w_byte_acc && !w_boundary) begin
                hold_q       <= bus.byte_data;
                hold_valid_q <= 1'b1;
            end else if (w_boundary && hold_valid_q) begin
                hold_valid_q <= 1'b0;
            end
            if (w_byte_acc) begin
                req_q <= req_q + 8'd1;
            end

            if ((state_q == ST_IDLE) || (state_q == ST_FIN)) begin
                sym_cnt_q <= 8'd0;
            end else begin
                sym_cnt_q <= w_sym_wrap ? 8'd0 : sym_cnt_q + 8'd1;
            end

            // Byte boundary: load the shift register or abort on an empty source.
            if (w_boundary) begin
                bit_cnt_q <= 5'd0;
                if (w_byte_avail) begin
                    state_q <= ST_PDU;
                    sym_q   <= w_byte_src[0];
                    shift_q <= {1'b0, w_byte_src[7:1]};
                    load_q  <= load_q + 8'd1;
                end else begin
                    state_q    <= ST_FIN;
                    sym_q      <= 1'b0;
                    mod_en_q   <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    underrun_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start) begin
                            state_q      <= ST_PRE;
                            acc_q        <= bus.acc_addr;
                            len_q        <= bus.pdu_len;
                            req_q        <= 8'd0;
                            load_q       <= 8'd0;
                            hold_valid_q <= 1'b0;
                            bit_cnt_q    <= 5'd0;
                            sym_q        <= bus.acc_addr[0];
                            mod_en_q     <= 1'b1;
                            busy_q       <= 1'b1;
                            underrun_q   <= 1'b0;
                        end
                    end
                    ST_PRE: begin
                        if (w_sym_wrap) begin
                            if (bit_cnt_q == C_PRE_LAST) begin
                                state_q   <= ST_AA;
                                bit_cnt_q <= 5'd0;
                                sym_q     <= acc_q[0];
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                                sym_q     <= w_pre_pat[bit_cnt_q[2:0] + 3'd1];
                            end
                        end
                    end
                    ST_AA: begin
                        if (w_aa_end) begin
                            state_q   <= ST_CRC;
                            bit_cnt_q <= 5'd0;
                            sym_q     <= w_crc[23];
                        end else if (w_sym_wrap) begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            sym_q     <= acc_q[bit_cnt_q + 5'd1];
                        end
                    end
                    ST_PDU: begin
                        if (w_pdu_end) begin
                            state_q   <= ST_CRC;
                            bit_cnt_q <= 5'd0;
                            sym_q     <= w_crc[23];
                        end else if (w_sym_wrap) begin
                            bit_cnt_q <= bit_cnt_q + 5'd1;
                            sym_q     <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                        end
                    end
                    ST_CRC: begin
                        if (w_sym_wrap) begin
                            if (bit_cnt_q == C_CRC_LAST) begin
                                state_q  <= ST_FIN;
                                sym_q    <= 1'b0;
                                mod_en_q <= 1'b0;
                                busy_q   <= 1'b0;
                                done_q   <= 1'b1;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                                sym_q     <= w_crc[22];
                            end
                        end
                    end
                    ST_FIN: begin
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.byte_ready = w_byte_ready;
    assign bus.symVal     = sym_q;
    assign bus.mod_en     = mod_en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.underrun   = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ble_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_ble_tx_sequencer
// Brief   : Directed frame-level bench for ble_tx_sequencer.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ble_tx_sequencer;

    localparam int CPS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ble_tx_sequencer_if bus ();

    ble_tx_sequencer #(
        .CLKS_PER_SYM (CPS),
        .CRC_INIT     (24'h555555)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_vec     = 0;
    int   n_err     = 0;
    logic cyc_q[$];
    int   done_cnt  = 0;
    logic done_mod_en = 1'b0;
    int   hs_cnt    = 0;
    int   late_cnt  = 0;
    int   exp_len   = 0;
    logic [7:0] src_mem [0:7];
    int   src_n     = 0;
    int   src_idx   = 0;

    // Symbol/handshake monitor on the falling edge.
    always @(negedge clk) begin
        if (bus.mod_en) cyc_q.push_back(bus.symVal);
        if (bus.done) begin
            done_cnt++;
            done_mod_en = bus.mod_en;
        end
        if (bus.byte_ready && (hs_cnt >= exp_len)) late_cnt++;
    end

    // Upstream byte source: presents src_mem[] in order whenever data remains.
    always @(posedge clk) begin
        if (bus.byte_valid && bus.byte_ready) begin
            src_idx++;
            hs_cnt++;
        end
        #1;
        if (src_idx < src_n) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = src_mem[src_idx];
        end else begin
            bus.byte_valid = 1'b0;
            bus.byte_data  = 8'h00;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int s, input int n, input bit msb);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            int   idx;
            logic b;
            idx = (s + i) * CPS;
            b   = (idx < cyc_q.size()) ? cyc_q[idx] : 1'bx;
            if (msb) v[n-1-i] = b;
            else     v[i]     = b;
        end
        return v;
    endfunction

    function automatic int hold_errs();
        int e;
        e = 0;
        for (int k = 0; k < cyc_q.size(); k++) begin
            if (cyc_q[k] !== cyc_q[k - (k % CPS)]) e++;
        end
        return e;
    endfunction

    function automatic logic [23:0] crc_model(input logic [15:0] bits, input int n);
        logic [23:0] c;
        logic        fb;
        c = 24'h555555;
        for (int i = 0; i < n; i++) begin
            fb = bits[i] ^ c[23];
            c  = {c[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h000000);
        end
        return c;
    endfunction

    task automatic start_frame(input logic [31:0] aa, input logic [7:0] len);
        cyc_q.delete();
        hs_cnt   = 0;
        late_cnt = 0;
        src_idx  = 0;
        exp_len  = len;
        bus.acc_addr = aa;
        bus.pdu_len  = len;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string tag);
        int t;
        t = 0;
        while ((done_cnt == d0) && (t < 20000)) begin
            @(posedge clk); #1;
            t++;
        end
        check(tag, done_cnt, d0 + 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        bus.start      = 1'b0;
        bus.acc_addr   = 32'd0;
        bus.pdu_len    = 8'd0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_symVal",     bus.symVal,     1'b0);
        check("rst_mod_en",     bus.mod_en,     1'b0);
        check("rst_busy",       bus.busy,       1'b0);
        check("rst_done",       bus.done,       1'b0);
        check("rst_underrun",   bus.underrun,   1'b0);
        check("rst_byte_ready", bus.byte_ready, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reference frame, empty PDU
        d0 = done_cnt;
        start_frame(32'h8E89BED6, 8'd0);
        check("f1_busy", bus.busy, 1'b1);
        wait_done(d0, "f1_done");
        check("f1_pre",      pack(0, 8, 0),   32'h000000AA);
        check("f1_aa",       pack(8, 32, 0),  32'h8E89BED6);
        check("f1_crc",      pack(40, 24, 1), 32'h00555555);
        check("f1_cycles",   cyc_q.size(),    256);
        check("f1_hold",     hold_errs(),     0);
        check("f1_underrun", bus.underrun,    1'b0);
        check("f1_done_mod", done_mod_en,     1'b0);

        // Payload frame, two bytes
        src_mem[0] = 8'h02;
        src_mem[1] = 8'h00;
        src_n      = 2;
        d0 = done_cnt;
        start_frame(32'h8E89BED6, 8'd2);
        wait_done(d0, "f2_done");
        check("f2_cycles", cyc_q.size(),    320);
        check("f2_aa",     pack(8, 32, 0),  32'h8E89BED6);
        check("f2_pdu",    pack(40, 16, 0), 32'h00000002);
        check("f2_crc",    pack(56, 24, 1), {8'h00, crc_model(16'h0002, 16)});
        check("f2_hs",     hs_cnt,          2);
        check("f2_late",   late_cnt,        0);
        check("f2_hold",   hold_errs(),     0);

        // Underrun: three bytes announced, one supplied
        src_mem[0] = 8'hC3;
        src_n      = 1;
        d0 = done_cnt;
        start_frame(32'h8E89BED6, 8'd3);
        wait_done(d0, "f3_done");
        check("f3_cycles",   cyc_q.size(),   192);
        check("f3_pdu",      pack(40, 8, 0), 32'h000000C3);
        check("f3_underrun", bus.underrun,   1'b1);
        check("f3_busy",     bus.busy,       1'b0);
        check("f3_done_mod", done_mod_en,    1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("f3_sticky",   bus.underrun,   1'b1);
        src_n = 0;

        // Preamble select; next start clears underrun
        d0 = done_cnt;
        start_frame(32'h00000001, 8'd0);
        check("f4_uclr",   bus.underrun, 1'b0);
        check("f4_mod_en", bus.mod_en,   1'b1);
        wait_done(d0, "f4_done");
        check("f4_pre",    pack(0, 8, 0),  32'h00000055);
        check("f4_aa",     pack(8, 32, 0), 32'h00000001);
        check("f4_cycles", cyc_q.size(),   256);

        // Start during AA is ignored
        d0 = done_cnt;
        start_frame(32'h8E89BED6, 8'd0);
        repeat (48) @(posedge clk);
        #1;
        bus.acc_addr = 32'h12345678;
        bus.pdu_len  = 8'd5;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        wait_done(d0, "f5_done");
        check("f5_aa",     pack(8, 32, 0),  32'h8E89BED6);
        check("f5_crc",    pack(40, 24, 1), 32'h00555555);
        check("f5_cycles", cyc_q.size(),    256);
        check("f5_dcount", done_cnt,        d0 + 1);

        // Asynchronous reset mid-PDU (symbol 45 = bit 5 of 0xAB = 1)
        src_mem[0] = 8'hAB;
        src_mem[1] = 8'hCD;
        src_n      = 2;
        start_frame(32'h8E89BED6, 8'd2);
        repeat (180) @(posedge clk);
        #3;
        check("f6_presym", bus.symVal, 1'b1);
        rst_n = 1'b0;
        #1;
        check("f6_rst_mod_en", bus.mod_en,     1'b0);
        check("f6_rst_busy",   bus.busy,       1'b0);
        check("f6_rst_sym",    bus.symVal,     1'b0);
        check("f6_rst_bready", bus.byte_ready, 1'b0);
        d0    = done_cnt;
        src_n = 0;
        repeat (5) @(posedge clk);
        #1;
        check("f6_no_done", done_cnt, d0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        d0 = done_cnt;
        start_frame(32'h8E89BED6, 8'd0);
        wait_done(d0, "f7_done");
        check("f7_pre",    pack(0, 8, 0),   32'h000000AA);
        check("f7_aa",     pack(8, 32, 0),  32'h8E89BED6);
        check("f7_crc",    pack(40, 24, 1), 32'h00555555);
        check("f7_cycles", cyc_q.size(),    256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ble_tx_sequencer.md
Name: ble_tx_sequencer

Overview:
Frame-level controller that drives the FSK modulator's symVal input for one BLE link-layer packet.
- Emits, in order: preamble, 32-bit access address, PDU bytes pulled from an upstream byte stream, and CRC24.
- Paces one symbol every CLKS_PER_SYM clocks.
- Gates the modulator with mod_en and reports busy/done/underrun to the host control logic.

Parameters:
CLKS_PER_SYM, 4, clocks per symbol (4 MHz clk -> 1 Msym/s); legal range 2..255
CRC_INIT, 24'h555555, CRC24 LFSR seed (advertising channel default)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to send a frame; sampled only in IDLE
acc_addr  in  32  access address; captured on accepted start
pdu_len  in  8  PDU byte count, 0..255; captured on accepted start
byte_data  in  8  PDU byte, transmitted LSB first
byte_valid  in  1  byte_data valid
byte_ready  out  1  sequencer can accept a byte; transfer on byte_valid && byte_ready
symVal  out  1  current symbol bit to the modulator
mod_en  out  1  high while symbols are on air
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at frame end (normal or aborted)
underrun  out  1  sticky error flag; cleared by the next accepted start

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. Outputs symVal=0, mod_en=0, busy=0, done=0, underrun=0, byte_ready=0. Holding register empty.
- States: IDLE -> PRE -> AA -> PDU -> CRC -> FIN -> IDLE.
- PDU is skipped when pdu_len=0 (AA -> CRC).
- Any state -> FIN on underrun.
- Accepted start: start=1 in IDLE.
  - Captures acc_addr/pdu_len and sets busy.
  - Clears underrun and seeds crc=CRC_INIT.
  - Next cycle: PRE, mod_en=1, first symbol driven on symVal.
  - start in any other state is ignored.
- Symbol timer: sym_cnt counts 0..CLKS_PER_SYM-1.
  - symVal changes only when sym_cnt wraps.
  - Each symbol is held exactly CLKS_PER_SYM cycles.
- PRE: 8 symbols.
  - Pattern is 8'hAA if acc_addr[0]=0, else 8'h55, sent LSB first.
  - Therefore the first preamble bit equals acc_addr[0].
- AA: 32 symbols, acc_addr[0] first.
- PDU: 8*pdu_len symbols, each byte LSB first.
  - A one-byte holding register prefetches data.
  - byte_ready=1 while busy, the holding register is empty, and bytes_requested < pdu_len.
  - byte_ready is deasserted after pdu_len bytes have been accepted.
  - Prefetch opens at AA entry, so the first byte may arrive during AA.
  - At each byte boundary (AA->PDU entry, or after the 8th bit of a byte) the holding register moves to the shift register.
  - Underrun: if the holding register is empty at a byte boundary, set underrun=1, drop mod_en and symVal to 0 that cycle, go to FIN.
- CRC24:
  - Polynomial x^24+x^10+x^9+x^6+x^4+x^3+x+1, Galois LFSR.
  - Shifted once per transmitted PDU bit: fb = bit ^ crc[23]; crc = {crc[22:0],0} ^ (fb ? 24'h00065B : 0).
  - The update happens when the bit is launched.
- CRC state: 24 symbols, crc[23] first, shifting left.
  - With pdu_len=0 the transmitted CRC equals CRC_INIT.
- FIN: lasts one cycle.
  - mod_en=0, symVal=0, done=1, busy=0.
  - Then IDLE; a new start is accepted the cycle after done.
- Frame length: normal frame has mod_en high for exactly (64+8*pdu_len)*CLKS_PER_SYM cycles.
- Simultaneous byte handshake and boundary: a byte accepted in the same cycle as the boundary it is needed for counts as present, with no underrun. This requires a bypass from byte_data into the shift register.
- Reset mid-frame: immediate return to IDLE with reset values.
  - No done pulse is generated.
  - Upstream must flush its pending bytes.

Decomposition:
- Shared package ble_tx_pkg holds:
  - state enum
  - BLE_PREAMBLE_LEN=8, BLE_AA_LEN=32, BLE_CRC_LEN=24
  - BLE_CRC_POLY=24'h00065B
- Sub-module ble_crc24 (clk, rst, init, seed, shift_en, din, crc). Contains the LFSR only and is reusable by the RX path.

Test Plan:
- Reference frame. CLKS_PER_SYM=4, acc_addr=32'h8E89BED6, pdu_len=0, start pulse.
  - First 8 symbols are 0,1,0,1,0,1,0,1.
  - Next 32 are 0x8E89BED6 LSB first.
  - Last 24 are 0x555555 MSB first.
  - mod_en high exactly 256 cycles; done pulses once; underrun=0.
- Payload frame. pdu_len=2, bytes 8'h02, 8'h00 supplied on request.
  - 80 symbols sent.
  - CRC bits match the bench software model of the 16 PDU bits.
  - byte_ready never asserts after the 2nd accept.
- Preamble select. acc_addr=32'h00000001 -> first 8 symbols 1,0,1,0,1,0,1,0.
- Underrun. pdu_len=3, supply 1 byte only.
  - At the 2nd byte boundary: underrun=1, mod_en falls within that cycle, done pulses.
  - underrun stays 1 until the next start.
- Start while busy is ignored. Second start during AA has no effect on the symbol stream or captured acc_addr.
- Reset mid-PDU. rst=0 asynchronously.
  - mod_en, busy and symVal go 0 without a clock edge; no done pulse.
  - After release, a new frame transmits correctly.
